// File: rtl/microfono_pdm_capture.sv
// PDM microphone capture: drives mic_clk, decimates by counting ones per window, buffers samples in a FIFO.
// Build macro MIC_SIGNED_OUTPUT_EN stores samples as two's complement (ones - WINDOW/2).
module microfono_pdm_capture #(
  parameter int MIC_DIV = 2,
  parameter int WINDOW  = 32,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              micData,
  input  logic              wr,
  input  logic              rd,
  output logic              mic_clk,
  output logic              mic_lrsel,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam int DIV_W = (MIC_DIV > 1) ? $clog2(MIC_DIV) : 1;
  localparam int BIT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [DIV_W-1:0]  div_q, div_d;
  logic              mic_clk_q, mic_clk_d;
  logic              sync1_q, sync2_q;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d;
  logic              rd_d_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              div_wrap, bit_strobe, last_bit, sample_valid;
  logic              pop_ok, push_ok;
  logic [DATA_W-1:0] ones, sample;

  assign div_wrap     = (div_q == DIV_W'(MIC_DIV - 1));
  assign bit_strobe   = div_wrap & ~mic_clk_q;
  assign last_bit     = (bit_cnt_q == BIT_W'(WINDOW - 1));
  assign sample_valid = bit_strobe & last_bit;
  assign ones         = acc_q + DATA_W'(sync2_q);
`ifdef MIC_SIGNED_OUTPUT_EN
  assign sample       = ones - DATA_W'(WINDOW / 2);
`else
  assign sample       = ones;
`endif

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign pop_ok   = rd & ~rd_d_q & ~empty;
  assign push_ok  = sample_valid & wr & (~full | pop_ok);

  always_comb begin
    div_d     = div_wrap ? '0 : div_q + DIV_W'(1);
    mic_clk_d = mic_clk_q ^ div_wrap;
    bit_cnt_d = bit_cnt_q;
    acc_d     = acc_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dout_d    = dout_q;
    ovf_d     = ovf_q | (sample_valid & wr & ~push_ok);

    if (bit_strobe) begin
      if (last_bit) begin
        bit_cnt_d = '0;
        acc_d     = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        acc_d     = ones;
      end
    end

    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      dout_d   = mem_q[rd_ptr_q];
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      mic_clk_q <= 1'b0;
      bit_cnt_q <= '0;
      acc_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dout_q    <= '0;
      ovf_q     <= 1'b0;
      rd_d_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      mic_clk_q <= mic_clk_d;
      bit_cnt_q <= bit_cnt_d;
      acc_q     <= acc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dout_q    <= dout_d;
      ovf_q     <= ovf_d;
      rd_d_q    <= rd;
    end
  end

  // Synchronizer keeps running through reset so the first window sees real mic data.
  always_ff @(posedge clk) begin
    sync1_q <= micData;
    sync2_q <= sync1_q;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= sample;
  end

  assign mic_clk   = mic_clk_q;
  assign mic_lrsel = 1'b0;
  assign dout      = dout_q;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_microfono_pdm_capture.sv
// Bench for microfono_pdm_capture: queue-based sample model checked every cycle, plus literal pins.
module tb_microfono_pdm_capture;
  localparam int MIC_DIV = 2;
  localparam int WINDOW  = 32;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 16;
`ifdef MIC_SIGNED_OUTPUT_EN
  localparam int OFFS = WINDOW / 2;
`else
  localparam int OFFS = 0;
`endif
  localparam logic [7:0] LIT_ONES = 8'(WINDOW - OFFS);
  localparam logic [7:0] LIT_ALT  = 8'(WINDOW / 2 - OFFS);
  localparam logic [7:0] LIT_ZERO = 8'(0 - OFFS);

  logic              clk, reset, micData, wr, rd;
  logic              mic_clk, mic_lrsel, empty, full, overflow;
  logic [DATA_W-1:0] dout;
  logic [ADDR_W:0]   count;

  microfono_pdm_capture #(
    .MIC_DIV(MIC_DIV), .WINDOW(WINDOW), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .micData(micData), .wr(wr), .rd(rd),
    .mic_clk(mic_clk), .mic_lrsel(mic_lrsel), .dout(dout), .empty(empty),
    .full(full), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  int         k, acc, nb, samples_done, mode, mode_next;
  logic [7:0] q[$];
  logic [7:0] exp_dout;
  logic       exp_ovf, rd_prev, in_reset;
  int         n_vec, n_bad;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("count", int'(count), q.size());
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("full", int'(full), int'(q.size() == DEPTH));
    chk("overflow", int'(overflow), int'(exp_ovf));
    chk("dout", int'(dout), int'(exp_dout));
    chk("mic_clk", int'(mic_clk), in_reset ? 0 : (k / MIC_DIV) % 2);
    chk("mic_lrsel", int'(mic_lrsel), 0);
  endtask

  // One clk cycle: apply model effects of this edge, check, then drive the next mic bit.
  task automatic tick();
    bit rise, done;
    logic [7:0] s;
    rise = 1'b0;
    done = 1'b0;
    @(posedge clk);
    if (!in_reset) begin
      k++;
      if (rd && !rd_prev && q.size() > 0) exp_dout = q.pop_front();
      rise = ((k % (2 * MIC_DIV)) == MIC_DIV);
      if (rise) begin
        acc += int'(micData);
        nb++;
        if (nb == WINDOW) begin
          s = 8'(acc - OFFS);
          if (wr) begin
            if (q.size() < DEPTH) q.push_back(s);
            else exp_ovf = 1'b1;
          end
          acc = 0;
          nb = 0;
          samples_done++;
          done = 1'b1;
        end
      end
      rd_prev = rd;
    end
    #1;
    compare_all();
    if (rise) begin
      if (done && mode != mode_next) begin
        mode = mode_next;
        micData = (mode != 0);
      end else if (mode == 2) micData = ~micData;
      else micData = (mode == 1);
    end
  endtask

  task automatic wait_samples(input int n);
    int target;
    target = samples_done + n;
    for (int i = 0; i < n * WINDOW * 2 * MIC_DIV + 10 && samples_done < target; i++) tick();
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
  endtask

  task automatic assert_reset();
    #2;
    reset = 1'b0;
    in_reset = 1'b1;
    q.delete();
    exp_dout = '0;
    exp_ovf = 1'b0;
    acc = 0;
    nb = 0;
    k = 0;
    rd_prev = 1'b0;
    mode = mode_next;
    micData = (mode != 0);
    #1;
    chk("lit_rst_count", int'(count), 0);
    chk("lit_rst_empty", int'(empty), 1);
    chk("lit_rst_full", int'(full), 0);
    chk("lit_rst_dout", int'(dout), 0);
    chk("lit_rst_mic_clk", int'(mic_clk), 0);
    chk("lit_rst_overflow", int'(overflow), 0);
  endtask

  task automatic release_reset();
    reset = 1'b1;
    in_reset = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    k = 0; acc = 0; nb = 0; samples_done = 0;
    mode = 1; mode_next = 1;
    exp_dout = '0; exp_ovf = 1'b0; rd_prev = 1'b0; in_reset = 1'b1;
    reset = 1'b0; wr = 1'b1; rd = 1'b0; micData = 1'b1;

    repeat (4) tick();
    chk("lit_init_count", int'(count), 0);
    chk("lit_init_empty", int'(empty), 1);
    chk("lit_init_dout", int'(dout), 0);
    chk("lit_init_mic_clk", int'(mic_clk), 0);
    release_reset();

    // first window of ones lands on edge 126 after release
    repeat (125) tick();
    chk("lit_first_not_yet", int'(count), 0);
    tick();
    chk("lit_first_count", int'(count), 1);
    pop();
    chk("lit_first_dout", int'(dout), int'(LIT_ONES));
    chk("lit_first_empty", int'(empty), 1);

    // ones, alternating, zeros
    mode_next = 2; wait_samples(1);
    mode_next = 0; wait_samples(1);
    wait_samples(1);
    chk("lit_three_count", int'(count), 3);
    pop(); chk("lit_ones", int'(dout), int'(LIT_ONES));
    pop(); chk("lit_alt", int'(dout), int'(LIT_ALT));
    pop(); chk("lit_zero", int'(dout), int'(LIT_ZERO));

    // capture disabled; pop on empty is ignored
    wr = 1'b0; mode_next = 1;
    wait_samples(5);
    chk("lit_wr0_count", int'(count), 0);
    pop();
    chk("lit_wr0_dout_hold", int'(dout), int'(LIT_ZERO));
    chk("lit_wr0_count_after_pop", int'(count), 0);

    // fill past full
    wr = 1'b1;
    wait_samples(17);
    chk("lit_full_count", int'(count), 16);
    chk("lit_full_flag", int'(full), 1);
    chk("lit_full_ovf", int'(overflow), 1);
    wr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pop();
      chk("lit_drain_dout", int'(dout), int'(LIT_ONES));
    end
    chk("lit_drain_empty", int'(empty), 1);

    // rd held high pops once
    wr = 1'b1; wait_samples(2); wr = 1'b0;
    rd = 1'b1;
    repeat (100) tick();
    rd = 1'b0;
    tick();
    chk("lit_hold_count", int'(count), 1);

    // reset mid-window with 5 stored
    tick(); tick();
    rd = 1'b1; tick(); rd = 1'b0; tick();
    wr = 1'b1;
    wait_samples(5);
    chk("lit_pre_rst_count", int'(count), 5);
    repeat (40) tick();
    mode_next = 1;
    assert_reset();
    repeat (3) tick();
    release_reset();
    repeat (125) tick();
    chk("lit_fresh_not_yet", int'(count), 0);
    tick();
    chk("lit_fresh_count", int'(count), 1);
    pop();
    chk("lit_fresh_dout", int'(dout), int'(LIT_ONES));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/microfono_pdm_capture.md
Name: microfono_pdm_capture

Overview:
- Captures a 1-bit PDM microphone stream (micData) and drives the microphone bit clock.
- Decimates the stream by counting ones over a fixed window, giving one PCM sample per window.
- Stores samples in an internal FIFO while wr is high; a host pops them one at a time with rd.
- Sits between the board microphone pins and the audio/CPU data path.

Parameters:
MIC_DIV, 2, clk cycles per mic_clk half-period (mic_clk = clk/(2*MIC_DIV)); must be >=1
WINDOW, 32, PDM bits per PCM sample; must be <= 2^DATA_W-1
DATA_W, 8, PCM sample width
ADDR_W, 4, FIFO address width (depth 2^ADDR_W = 16)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
micData  input  1  PDM data from microphone (asynchronous to clk)
wr  input  1  capture enable: completed samples are pushed only while high
rd  input  1  read request; rising edge pops one sample
mic_clk  output  1  microphone bit clock
mic_lrsel  output  1  channel select; constant 0
dout  output  DATA_W  last popped sample
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  ADDR_W+1  FIFO occupancy, 0..2^ADDR_W
overflow  output  1  sticky: a sample was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, async): all counters, accumulators, FIFO pointers, mic_clk, dout, count and overflow = 0. empty=1, full=0. rd edge detector cleared.
- Clock divider: a counter runs 0..MIC_DIV-1; mic_clk toggles when it wraps.
- Bit strobe: a one-cycle bit strobe fires in the clk cycle where mic_clk goes 0->1.
- Input sync: micData passes through a 2-flop synchronizer. The synchronized value is sampled on each bit strobe.
- Decimator: a bit counter counts 0..WINDOW-1 and an accumulator adds each sampled bit.
  - On the WINDOW-th strobe: sample = accumulator + current bit.
  - sample_valid pulses for one cycle.
  - Accumulator and bit counter restart from 0 in the same cycle.
  - Values range 0..WINDOW.
- The decimator runs regardless of wr, so window alignment is continuous from reset.
- Push: on sample_valid with wr=1:
  - If not full: write at the write pointer, increment the pointer (wraps modulo 2^ADDR_W), count+1.
  - If full: drop the sample, set overflow=1. overflow clears only on reset.
- Pop: rd is edge-detected on clk (register rd_d; pop request = rd & ~rd_d).
  - If not empty: dout <= mem[rd_ptr] on the next rising edge, increment rd_ptr (wraps), count-1.
  - If empty: the request is ignored and dout holds.
  - Holding rd high pops only once.
- Simultaneous push and pop (neither blocked): both happen, count is unchanged.
- Simultaneous push and pop when full: the pop frees a slot, so the push succeeds.
- Simultaneous push and pop when empty: the pop is ignored, the push succeeds.
- empty = (count==0), full = (count==2^ADDR_W), both combinational from count.
- Latency: micData edge to sampled bit is 2-3 clk cycles. Last bit strobe of a window to sample in the FIFO is 1 cycle. rd edge to dout valid is 1 cycle.

Optional Feature:
Macro MIC_SIGNED_OUTPUT_EN.
- Defined: each sample is stored as a two's-complement value, ones_count - WINDOW/2 (e.g. all-zero window gives -16, all-one window gives +16 for WINDOW=32).
- Undefined: the unsigned ones count 0..WINDOW is stored.
- FIFO and handshake are identical in both builds.

Test Plan (default parameters, macro undefined):
- micData=1 constant, wr=1: after about 32 bit strobes (~128 clk cycles) count=1; rd pulse -> dout=0x20 one cycle later, count=0, empty=1.
- micData alternating 1/0 on each bit strobe, wr=1, one window -> stored sample 0x10. micData=0 for a window -> 0x00.
- wr=0 for 5 windows -> count stays 0, empty=1. Then rd pulse -> dout unchanged (0), no underflow effects.
- wr=1, micData=1 for 17 windows -> count=16, full=1, overflow=1. Then 16 rd pulses each return 0x20 and the FIFO ends empty. rd held high for 100 cycles pops exactly one sample.
- Reset asserted (reset=0) mid-window with count=5 -> immediately count=0, empty=1, dout=0, mic_clk=0, overflow=0. The first sample after release covers a full fresh window.
- Build with MIC_SIGNED_OUTPUT_EN: an all-zero window reads 0xF0 and an all-one window reads 0x10.
